// File: rtl/tdm_demux4_if.sv
// Bundle of the TDM word stream and the demultiplexed frame outputs.
// master: the stream source / frame consumer; slave: the demultiplexer.
interface tdm_demux4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             valid;
  logic             sof;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] Y1;
  logic [WIDTH-1:0] Y2;
  logic [WIDTH-1:0] Y3;
  logic [1:0]       S;
  logic             locked;
  logic             frame_valid;
  logic             sync_err;

  modport master (
    output D, valid, sof,
    input  Y0, Y1, Y2, Y3, S, locked, frame_valid, sync_err
  );

  modport slave (
    input  D, valid, sof,
    output Y0, Y1, Y2, Y3, S, locked, frame_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer. Words arrive serially (channel 0 first,
// marked by sof); channels 0..2 are staged in a shadow buffer and all four
// outputs update together on the edge that accepts the channel-3 word, so a
// partial or aborted frame never becomes visible on Y0..Y3.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       s_reg, s_next;
  logic             fv_reg, fv_next;
  logic             err_reg, err_next;

  // Channel 3 is never staged: it goes straight from D into Y3.
  logic [WIDTH-1:0] shadow_reg  [0:2];
  logic [WIDTH-1:0] shadow_next [0:2];
  logic [WIDTH-1:0] y_reg       [0:3];
  logic [WIDTH-1:0] y_next      [0:3];

  logic             shadow_we;
  logic [1:0]       shadow_idx;
  logic             load_y;

  // Next-state, channel counter and error decisions for one accepted word.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    fv_next    = 1'b0;
    err_next   = err_reg;
    shadow_we  = 1'b0;
    shadow_idx = s_reg;
    load_y     = 1'b0;

    if (bus.valid) begin
      case (state_reg)
        HUNT: begin
          if (bus.sof) begin
            shadow_we  = 1'b1;
            shadow_idx = 2'd0;
            s_next     = 2'd1;
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.sof) begin
            // sof mid-frame is an early restart: drop the partial frame.
            if (s_reg != 2'd0) begin
              err_next = 1'b1;
            end
            shadow_we  = 1'b1;
            shadow_idx = 2'd0;
            s_next     = 2'd1;
          end else if (s_reg == 2'd0) begin
            // Channel 0 without sof means alignment is lost.
            err_next   = 1'b1;
            s_next     = 2'd0;
            state_next = HUNT;
          end else if (s_reg == 2'd3) begin
            load_y  = 1'b1;
            fv_next = 1'b1;
            s_next  = 2'd0;
          end else begin
            shadow_we = 1'b1;
            s_next    = s_reg + 2'd1;
          end
        end
        default: begin
          state_next = HUNT;
          s_next     = 2'd0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
      assign shadow_next[gi] = (shadow_we && (shadow_idx == 2'(gi))) ? bus.D
                                                                      : shadow_reg[gi];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_y
      if (gi < 3) begin : g_staged
        assign y_next[gi] = load_y ? shadow_reg[gi] : y_reg[gi];
      end else begin : g_direct
        assign y_next[gi] = load_y ? bus.D : y_reg[gi];
      end
    end
  endgenerate

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HUNT;
      s_reg     <= 2'd0;
      fv_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      fv_reg    <= fv_next;
      err_reg   <= err_next;
    end
  end

  // Shadow buffer and frame output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '{default: '0};
      y_reg      <= '{default: '0};
    end else begin
      shadow_reg <= shadow_next;
      y_reg      <= y_next;
    end
  end

  assign bus.Y0          = y_reg[0];
  assign bus.Y1          = y_reg[1];
  assign bus.Y2          = y_reg[2];
  assign bus.Y3          = y_reg[3];
  assign bus.S           = s_reg;
  assign bus.locked      = (state_reg == LOCKED);
  assign bus.frame_valid = fv_reg;
  assign bus.sync_err    = err_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: a vector table of per-cycle stimulus and expected
// outputs, plus a hand-written back-to-back frame sequence. Expected frames
// are queued when the channel-3 word is driven and checked on frame_valid.
module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  tdm_demux4_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic        f;
    logic [7:0]  d;
    logic [31:0] y;    // {Y0,Y1,Y2,Y3} after the edge
    logic [1:0]  s;
    logic        lk;
    logic        fv;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pulses  = 0;

  task automatic add(input logic r, input logic v, input logic f, input logic [7:0] d,
                     input logic [31:0] y, input logic [1:0] s, input logic lk,
                     input logic fv, input logic err);
    vec_t t;
    t.r = r; t.v = v; t.f = f; t.d = d; t.y = y;
    t.s = s; t.lk = lk; t.fv = fv; t.err = err;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] y_now();
    return {bus.Y0, bus.Y1, bus.Y2, bus.Y3};
  endfunction

  // Scoreboard side: a frame_valid pulse must match the oldest queued frame.
  task automatic observe(input int idx);
    logic [31:0] e;
    if (bus.frame_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_frame", idx, y_now(), 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        check("sb_frame", idx, y_now(), e);
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic f, input logic [7:0] d);
    @(negedge clk);
    rst       = r;
    bus.valid = v;
    bus.sof   = f;
    bus.D     = d;
    @(posedge clk);
    #1;
  endtask

  int step;

  initial begin
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.sof   = 1'b0;
    bus.D     = '0;
    step      = 0;

    // Reset state
    add(1,0,0,8'h00, 32'h0,         2'd0,0,0,0);
    // Basic frame, then the pulse drops and sof without valid is ignored
    add(0,1,1,8'hA1, 32'h0,         2'd1,1,0,0);
    add(0,1,0,8'hB2, 32'h0,         2'd2,1,0,0);
    add(0,1,0,8'hC3, 32'h0,         2'd3,1,0,0);
    add(0,1,0,8'hD4, 32'hA1B2C3D4,  2'd0,1,1,0);
    add(0,0,0,8'h00, 32'hA1B2C3D4,  2'd0,1,0,0);
    add(0,0,1,8'hEE, 32'hA1B2C3D4,  2'd0,1,0,0);
    // Reset wins over valid/sof; then the same frame with 2-cycle gaps
    add(1,1,1,8'hFF, 32'h0,         2'd0,0,0,0);
    add(0,1,1,8'hA1, 32'h0,         2'd1,1,0,0);
    add(0,0,1,8'h99, 32'h0,         2'd1,1,0,0);
    add(0,0,0,8'h00, 32'h0,         2'd1,1,0,0);
    add(0,1,0,8'hB2, 32'h0,         2'd2,1,0,0);
    add(0,0,0,8'h00, 32'h0,         2'd2,1,0,0);
    add(0,0,0,8'h00, 32'h0,         2'd2,1,0,0);
    add(0,1,0,8'hC3, 32'h0,         2'd3,1,0,0);
    add(0,0,1,8'h99, 32'h0,         2'd3,1,0,0);
    add(0,0,0,8'h00, 32'h0,         2'd3,1,0,0);
    add(0,1,0,8'hD4, 32'hA1B2C3D4,  2'd0,1,1,0);
    add(0,0,0,8'h00, 32'hA1B2C3D4,  2'd0,1,0,0);
    // Hunt: words without sof are discarded
    add(1,0,0,8'h00, 32'h0,         2'd0,0,0,0);
    add(0,1,0,8'h11, 32'h0,         2'd0,0,0,0);
    add(0,1,0,8'h22, 32'h0,         2'd0,0,0,0);
    add(0,1,1,8'h01, 32'h0,         2'd1,1,0,0);
    add(0,1,0,8'h02, 32'h0,         2'd2,1,0,0);
    add(0,1,0,8'h03, 32'h0,         2'd3,1,0,0);
    add(0,1,0,8'h04, 32'h01020304,  2'd0,1,1,0);
    // Early sof aborts the 10/20 partial frame
    add(0,1,1,8'hAA, 32'h01020304,  2'd1,1,0,0);
    add(0,1,0,8'hBB, 32'h01020304,  2'd2,1,0,0);
    add(0,1,0,8'hCC, 32'h01020304,  2'd3,1,0,0);
    add(0,1,0,8'hDD, 32'hAABBCCDD,  2'd0,1,1,0);
    add(0,1,1,8'h10, 32'hAABBCCDD,  2'd1,1,0,0);
    add(0,1,0,8'h20, 32'hAABBCCDD,  2'd2,1,0,0);
    add(0,1,1,8'h30, 32'hAABBCCDD,  2'd1,1,0,1);
    add(0,1,0,8'h40, 32'hAABBCCDD,  2'd2,1,0,1);
    add(0,1,0,8'h50, 32'hAABBCCDD,  2'd3,1,0,1);
    add(0,1,0,8'h60, 32'h30405060,  2'd0,1,1,1);
    // Missing sof at S=0 drops lock; sync_err sticks through the next frame
    add(1,0,0,8'h00, 32'h0,         2'd0,0,0,0);
    add(0,1,1,8'hE1, 32'h0,         2'd1,1,0,0);
    add(0,1,0,8'hE2, 32'h0,         2'd2,1,0,0);
    add(0,1,0,8'hE3, 32'h0,         2'd3,1,0,0);
    add(0,1,0,8'hE4, 32'hE1E2E3E4,  2'd0,1,1,0);
    add(0,1,0,8'h77, 32'hE1E2E3E4,  2'd0,0,0,1);
    add(0,1,1,8'h81, 32'hE1E2E3E4,  2'd1,1,0,1);
    add(0,1,0,8'h82, 32'hE1E2E3E4,  2'd2,1,0,1);
    add(0,1,0,8'h83, 32'hE1E2E3E4,  2'd3,1,0,1);
    add(0,1,0,8'h84, 32'h81828384,  2'd0,1,1,1);
    // Reset mid-frame: partial frame lost, later words need a new sof
    add(1,0,0,8'h00, 32'h0,         2'd0,0,0,0);
    add(0,1,1,8'h01, 32'h0,         2'd1,1,0,0);
    add(0,1,0,8'h02, 32'h0,         2'd2,1,0,0);
    add(1,1,1,8'h55, 32'h0,         2'd0,0,0,0);
    add(0,1,0,8'h03, 32'h0,         2'd0,0,0,0);
    add(0,1,0,8'h04, 32'h0,         2'd0,0,0,0);
    add(0,0,0,8'h00, 32'h0,         2'd0,0,0,0);

    foreach (vecs[i]) begin
      if (vecs[i].fv) exp_q.push_back(vecs[i].y);
      drive(vecs[i].r, vecs[i].v, vecs[i].f, vecs[i].d);
      observe(i);
      check("y",           i, y_now(),                  vecs[i].y);
      check("s",           i, 32'(bus.S),               32'(vecs[i].s));
      check("locked",      i, 32'(bus.locked),          32'(vecs[i].lk));
      check("frame_valid", i, 32'(bus.frame_valid),     32'(vecs[i].fv));
      check("sync_err",    i, 32'(bus.sync_err),        32'(vecs[i].err));
      $display("[TB] vec %0d rst=%0b v=%0b sof=%0b D=%h -> Y=%h S=%0d lk=%0b fv=%0b err=%0b",
               i, vecs[i].r, vecs[i].v, vecs[i].f, vecs[i].d, y_now(), bus.S,
               bus.locked, bus.frame_valid, bus.sync_err);
    end

    // Hand sequence: two back-to-back frames with no idle cycles
    step   = 1000;
    pulses = 0;
    drive(1, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] w;
      w = (k < 4) ? 8'(8'h31 + k) : 8'(8'h41 + k - 4);
      if (k == 3) exp_q.push_back(32'h31323334);
      if (k == 7) exp_q.push_back(32'h41424344);
      drive(0, 1, (k == 0 || k == 4), w);
      observe(step + k);
      $display("[TB] seq word %0d D=%h -> Y=%h S=%0d fv=%0b", k, w, y_now(), bus.S,
               bus.frame_valid);
    end
    // Bounded drain: any outstanding expected frame must have arrived
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      drive(0, 0, 0, 8'h00);
      observe(step + 8 + k);
    end
    check("sb_drain",  step, 32'(exp_q.size()), 32'd0);
    check("pulses",    step, 32'(pulses),       32'd2);
    // Outputs hold across idle cycles
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 8'h00);
    check("y_hold",    step, y_now(),                 32'h41424344);
    check("fv_idle",   step, 32'(bus.frame_valid),    32'd0);
    check("err_clean", step, 32'(bus.sync_err),       32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the data width of each channel word.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port D  input  WIDTH  serial TDM word stream, channel 0 first.
REQ-006 Port valid  input  1  D carries a word this cycle.
REQ-007 Port sof  input  1  start of frame; qualified by valid; marks the channel-0 word.
REQ-008 Port Y0  output  WIDTH  last complete frame, channel 0 (registered).
REQ-009 Ports Y1, Y2, Y3  output  WIDTH  last complete frame, channels 1, 2, 3 (registered).
REQ-010 Port S  output  2  channel index expected for the next accepted word.
REQ-011 Port locked  output  1  high while the FSM is in LOCKED.
REQ-012 Port frame_valid  output  1  one-cycle pulse when Y0..Y3 update.
REQ-013 Port sync_err  output  1  sticky framing-error flag.

Function
REQ-014 The FSM SHALL have two states: HUNT (waiting for sof) and LOCKED (collecting a frame).
REQ-015 A word SHALL be accepted only on a rising edge where valid=1; with valid=0 all state SHALL hold.
REQ-016 In HUNT, valid=1 with sof=0 SHALL be discarded with no state change.
REQ-017 In HUNT, valid=1 with sof=1 SHALL store D into shadow[0], set S=1, and enter LOCKED.
REQ-018 In LOCKED with S!=0, valid=1 with sof=0 SHALL store D into shadow[S] and increment S (2-bit, wraps 3->0).
REQ-019 On accepting the channel-3 word, Y0..Y3 SHALL load simultaneously: Y0..Y2 from shadow[0..2], Y3 from D.
REQ-020 On that same edge, frame_valid SHALL go high for exactly one cycle, S SHALL become 0, and the FSM SHALL stay LOCKED.
REQ-021 Latency SHALL be zero extra cycles: Y0..Y3 and frame_valid are valid immediately after the edge that accepts the channel-3 word.
REQ-022 In LOCKED with S=0, valid=1 with sof=1 SHALL store D into shadow[0] and set S=1 (normal frame start).
REQ-023 In LOCKED with S=0, valid=1 with sof=0 SHALL set sync_err, go to HUNT with S=0, and discard the word.
REQ-024 In LOCKED with S!=0, valid=1 with sof=1 (early sof) SHALL set sync_err, abort the partial frame, store D into shadow[0], and set S=1.
REQ-025 An aborted partial frame SHALL never reach Y0..Y3.
REQ-026 Y0..Y3 SHALL hold their values between frame_valid pulses.
REQ-027 sync_err SHALL clear only on rst.
REQ-028 sof with valid=0 SHALL be ignored.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL reset: FSM=HUNT, S=0, locked=0, frame_valid=0, sync_err=0, Y0..Y3=0, shadow=0.
REQ-030 rst SHALL take priority over valid/sof in the same cycle.
REQ-031 rst mid-frame SHALL discard the partial frame, leave Y0..Y3=0, and produce no frame_valid.
REQ-032 After rst deasserts, the block SHALL require a new sof before accepting data.

Verification
REQ-033 Basic frame: reset, then valid words A1(sof),B2,C3,D4 on consecutive cycles -> after the 4th edge Y0..Y3=A1,B2,C3,D4, frame_valid=1 for one cycle, S=0, sync_err=0.
REQ-034 Gaps: same frame with valid=0 for 2 cycles between each word -> identical Y values, one frame_valid pulse, S holds during the gaps.
REQ-035 Hunt: from reset, send 11,22 (no sof), then frame 01(sof),02,03,04 -> 11,22 discarded, locked stays 0 until the 01 word, Y=01,02,03,04.
REQ-036 Early sof: after frame AA..DD, send 10(sof),20,30(sof),40,50,60 -> sync_err=1 after the 30 word, Y=30,40,50,60, no Y update containing 10/20.
REQ-037 Missing sof: after one good frame, send 77 with sof=0 at S=0 -> sync_err=1, locked=0, Y unchanged; the next sof frame decodes normally and sync_err stays 1.
REQ-038 Reset mid-frame: send 01(sof),02, then rst for 1 cycle, then 03,04 (no sof) -> Y0..Y3=0, no frame_valid, locked=0, sync_err=0.
